// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants and position-to-width mapping for servo_pwm_bank
//
// Purpose: the derived constants (tick divider, counter widths, centre code,
// pulse span) and the position-code to pulse-width mapping. Everything here
// is computed from the instantiating module's parameters, so the
// helpers take those parameters as arguments.
package servo_pkg;

    // Clock cycles per microsecond tick.
    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1_000_000;
    endfunction

    // Width of a counter or index covering 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Mid-scale position code.
    function automatic int center_code(input int pos_w);
        return 1 << (pos_w - 1);
    endfunction

    // Pulse range covered by the position code.
    function automatic int span_us(input int min_us, input int max_us);
        return max_us - min_us;
    endfunction

    // Linear map: code 0 -> min_us, full-scale code -> max_us, rounding down.
    // The divisor depends only on pos_w, so it folds to a constant.
    function automatic int pos_to_us(input int pos, input int pos_w,
                                     input int min_us, input int max_us);
        return min_us + (pos * span_us(min_us, max_us)) / ((1 << pos_w) - 1);
    endfunction

endpackage

// File: rtl/servo_us_tick.sv
// rtl/servo_us_tick.sv - microsecond prescaler producing a one-cycle tick
//
// Ports:
//   clk_i   system clock
//   rst_ni  synchronous active-low reset
//   tick_o  high for one clock on the prescaler terminal count
module servo_us_tick #(
    parameter int TICK_DIV = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PS_W-1:0] ps_q, ps_d;
    logic            term;

    // With TICK_DIV=1 the counter sits at 0 and the tick is always high.
    assign term = (ps_q == PS_W'(TICK_DIV - 1));

    always_comb begin
        ps_d = ps_q + PS_W'(1);
        if (term) begin
            ps_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    assign tick_o = term;

endmodule

// File: rtl/servo_pwm_bank.sv
// rtl/servo_pwm_bank.sv - multi-channel servo PWM generator with frame-synchronous updates
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   wr_en        target write strobe
//   wr_ch        channel index for the write (indices >= CHANNELS are dropped)
//   wr_pos       target position code
//   pwm          registered servo pulse outputs
//   busy         registered per-channel "current position != target"
//   frame_start  one-cycle pulse following each frame boundary
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int CHANNELS  = 4,
    parameter int POS_W     = 8,
    parameter int PERIOD_US = 20_000,
    parameter int MIN_US    = 1_000,
    parameter int MAX_US    = 2_000,
    parameter int SLEW      = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [cnt_w(CHANNELS)-1:0] wr_ch,
    input  logic [POS_W-1:0]           wr_pos,
    output logic [CHANNELS-1:0]        pwm,
    output logic [CHANNELS-1:0]        busy,
    output logic                       frame_start
);

    localparam int TICK_DIV = tick_div(CLK_HZ);
    localparam int US_W     = cnt_w(PERIOD_US);
    localparam int CH_W     = cnt_w(CHANNELS);
    localparam int CENTER   = center_code(POS_W);

    localparam logic [POS_W-1:0] CENTER_C  = POS_W'(CENTER);
    localparam logic [US_W-1:0]  CENTER_US = US_W'(pos_to_us(CENTER, POS_W, MIN_US, MAX_US));
    // Slew larger than full scale behaves like full scale.
    localparam logic [POS_W-1:0] SLEW_C    = (SLEW >= 2 * CENTER) ? '1 : POS_W'(SLEW);

    logic            tick;
    logic [US_W-1:0] us_q, us_d;
    logic            frame_end;
    logic            frame_start_q;

    servo_us_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tick_o (tick)
    );

    assign frame_end = tick && (us_q == US_W'(PERIOD_US - 1));

    always_comb begin
        us_d = us_q;
        if (frame_end) begin
            us_d = '0;
        end else if (tick) begin
            us_d = us_q + US_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            us_q          <= '0;
            frame_start_q <= 1'b0;
        end else begin
            us_q          <= us_d;
            frame_start_q <= frame_end;
        end
    end

    assign frame_start = frame_start_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [POS_W-1:0] tgt_q, tgt_d;
        logic [POS_W-1:0] cur_q, cur_d;
        logic [US_W-1:0]  width_q, width_d;
        logic             pwm_q;
        logic             busy_q;

        // Out-of-range indices match no channel, so such writes vanish.
        always_comb begin
            tgt_d = tgt_q;
            if (wr_en && (wr_ch == CH_W'(g))) begin
                tgt_d = wr_pos;
            end
        end

        // Position only moves on the boundary edge; the target it sees is the
        // one registered before that edge, so a same-cycle write waits a frame.
        always_comb begin
            cur_d = cur_q;
            if (frame_end) begin
                if (SLEW == 0) begin
                    cur_d = tgt_q;
                end else if (tgt_q > cur_q) begin
                    cur_d = ((tgt_q - cur_q) > SLEW_C) ? cur_q + SLEW_C : tgt_q;
                end else if (tgt_q < cur_q) begin
                    cur_d = ((cur_q - tgt_q) > SLEW_C) ? cur_q - SLEW_C : tgt_q;
                end
            end
        end

        // Width follows cur one cycle after the boundary. The compare in that
        // same cycle still uses the old width against us_cnt=0, which is
        // always inside any pulse, so the pulse start is unaffected.
        always_comb begin
            width_d = width_q;
            if (frame_start_q) begin
                width_d = US_W'(pos_to_us(int'(cur_q), POS_W, MIN_US, MAX_US));
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                tgt_q   <= CENTER_C;
                cur_q   <= CENTER_C;
                width_q <= CENTER_US;
                pwm_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                tgt_q   <= tgt_d;
                cur_q   <= cur_d;
                width_q <= width_d;
                pwm_q   <= (us_q < width_q);
                busy_q  <= (cur_q != tgt_q);
            end
        end

        assign pwm[g]  = pwm_q;
        assign busy[g] = busy_q;
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb/tb_servo_pwm_bank.sv - self-checking bench for servo_pwm_bank
module tb_servo_pwm_bank;

    localparam int A_FRAME = 4200;   // 2100 us at 2 clk/us
    localparam int B_FRAME = 800;    // 400 us at 2 clk/us
    localparam int NWR     = 7;
    localparam int NFRM    = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, wr_en_a, fs_a;
    logic [1:0] wr_ch_a;
    logic [7:0] wr_pos_a;
    logic [3:0] pwm_a, busy_a;

    logic       rst_b, wr_en_b, fs_b;
    logic [1:0] wr_ch_b;
    logic [7:0] wr_pos_b;
    logic [2:0] pwm_b, busy_b;

    servo_pwm_bank #(
        .CLK_HZ(2_000_000), .CHANNELS(4), .POS_W(8), .PERIOD_US(2100),
        .MIN_US(1000), .MAX_US(2000), .SLEW(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_a), .wr_en(wr_en_a), .wr_ch(wr_ch_a),
        .wr_pos(wr_pos_a), .pwm(pwm_a), .busy(busy_a), .frame_start(fs_a)
    );

    // Span of 255 us makes width = 100 + cur, so the pulse reveals cur directly.
    servo_pwm_bank #(
        .CLK_HZ(2_000_000), .CHANNELS(3), .POS_W(8), .PERIOD_US(400),
        .MIN_US(100), .MAX_US(355), .SLEW(10)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .wr_en(wr_en_b), .wr_ch(wr_ch_b),
        .wr_pos(wr_pos_b), .pwm(pwm_b), .busy(busy_b), .frame_start(fs_b)
    );

    typedef struct {
        int frame;
        int off;
        int ch;
        int pos;
    } wr_t;

    typedef struct {
        int         us [4];
        logic [3:0] busy_mid;
    } frm_t;

    wr_t  wr_tab  [NWR];
    frm_t frm_tab [NFRM];

    int         n_pass  = 0;
    int         n_total = 0;
    int         hb [3];
    logic [2:0] busy_mid_b;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for frame_start", name);
    endtask

    task automatic wait_fs_a(input int limit, output int n);
        n = 0;
        while (fs_a !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) timeout("wait_fs_a");
    endtask

    task automatic wait_fs_b(input int limit, output int n);
        n = 0;
        while (fs_b !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) timeout("wait_fs_b");
    endtask

    // Runs one dut_b frame from its frame_start negedge, optionally writing once.
    task automatic frame_b(input int wr_off, input int ch, input int pos);
        for (int c = 0; c < 3; c++) hb[c] = 0;
        for (int off = 0; off < B_FRAME; off++) begin
            for (int c = 0; c < 3; c++) if (pwm_b[c]) hb[c]++;
            if (off == 400) busy_mid_b = busy_b;
            wr_en_b  = (off == wr_off);
            wr_ch_b  = 2'(ch);
            wr_pos_b = 8'(pos);
            @(negedge clk);
        end
        wr_en_b = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int hi [4];
        int n;
        int fs_seen;
        int expc;

        // Writes during measured frames of dut_a (frame index, cycle offset).
        wr_tab[0] = '{1, 100, 0, 0};
        wr_tab[1] = '{1, 101, 1, 255};
        wr_tab[2] = '{1, 102, 2, 128};
        wr_tab[3] = '{2, 4199, 3, 0};   // lands in the boundary cycle
        wr_tab[4] = '{3, 50, 0, 200};
        wr_tab[5] = '{3, 60, 0, 64};    // overrides the previous write
        wr_tab[6] = '{4, 10, 1, 1};

        // Pulse widths (us) seen in each frame, and busy at mid-frame.
        frm_tab[0] = '{'{1501, 1501, 1501, 1501}, 4'b0000};
        frm_tab[1] = '{'{1501, 1501, 1501, 1501}, 4'b0011};
        frm_tab[2] = '{'{1000, 2000, 1501, 1501}, 4'b0000};
        frm_tab[3] = '{'{1000, 2000, 1501, 1501}, 4'b1001};
        frm_tab[4] = '{'{1250, 2000, 1501, 1000}, 4'b0010};
        frm_tab[5] = '{'{1250, 1003, 1501, 1000}, 4'b0000};

        rst_a = 1'b0; wr_en_a = 1'b0; wr_ch_a = '0; wr_pos_a = '0;
        rst_b = 1'b0; wr_en_b = 1'b0; wr_ch_b = '0; wr_pos_b = '0;
        busy_mid_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_pwm_a",  int'(pwm_a),  0);
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_fs_a",   int'(fs_a),   0);
        chk("rst_pwm_b",  int'(pwm_b),  0);
        chk("rst_busy_b", int'(busy_b), 0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        wait_fs_a(5000, n);
        chk("a_first_frame_clk", n, A_FRAME);

        for (int f = 0; f < NFRM; f++) begin
            if (f > 0) begin
                wait_fs_a(10, n);
                chk($sformatf("a_f%0d_fs_gap", f), n, 0);
            end
            for (int c = 0; c < 4; c++) hi[c] = 0;
            fs_seen = 0;
            for (int off = 0; off < A_FRAME; off++) begin
                for (int c = 0; c < 4; c++) if (pwm_a[c]) hi[c]++;
                if (off > 0 && fs_a) fs_seen++;
                if (off == 2000)
                    chk($sformatf("a_f%0d_busy", f), int'(busy_a), int'(frm_tab[f].busy_mid));
                wr_en_a = 1'b0;
                for (int w = 0; w < NWR; w++) begin
                    if (wr_tab[w].frame == f && wr_tab[w].off == off) begin
                        wr_en_a  = 1'b1;
                        wr_ch_a  = 2'(wr_tab[w].ch);
                        wr_pos_a = 8'(wr_tab[w].pos);
                    end
                end
                @(negedge clk);
            end
            wr_en_a = 1'b0;
            for (int c = 0; c < 4; c++)
                chk($sformatf("a_f%0d_ch%0d_high_clk", f, c), hi[c], 2 * frm_tab[f].us[c]);
            chk($sformatf("a_f%0d_extra_fs", f), fs_seen, 0);
        end

        // Reset pulse in the middle of a high pulse.
        repeat (500) @(negedge clk);
        chk("a_midpulse_pwm", int'(pwm_a), 15);
        rst_a = 1'b0;
        @(negedge clk);
        chk("a_rst_pwm",  int'(pwm_a),  0);
        chk("a_rst_busy", int'(busy_a), 0);
        chk("a_rst_fs",   int'(fs_a),   0);
        rst_a = 1'b1;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        n = 0;
        while (fs_a !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
            for (int c = 0; c < 4; c++) if (pwm_a[c]) hi[c]++;
        end
        chk("a_after_rst_frame_clk", n, A_FRAME);
        for (int c = 0; c < 4; c++)
            chk($sformatf("a_after_rst_ch%0d_high_clk", c), hi[c], 3002);
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int off = 0; off < A_FRAME; off++) begin
            for (int c = 0; c < 4; c++) if (pwm_a[c]) hi[c]++;
            @(negedge clk);
        end
        for (int c = 0; c < 4; c++)
            chk($sformatf("a_centre_ch%0d_high_clk", c), hi[c], 3002);
        chk("a_centre_busy", int'(busy_a), 0);

        // dut_b: out-of-range channel write, then a slewed move of ch2 to 0.
        wait_fs_b(1000, n);
        frame_b(5, 3, 0);
        wait_fs_b(10, n);
        chk("b_fs_gap", n, 0);
        frame_b(-1, 0, 0);
        for (int c = 0; c < 3; c++)
            chk($sformatf("b_oor_ch%0d_high_clk", c), hb[c], 456);
        chk("b_oor_busy", int'(busy_mid_b), 0);

        wait_fs_b(10, n);
        frame_b(5, 2, 0);
        chk("b_pre_ramp_ch2_high_clk", hb[2], 456);
        chk("b_pre_ramp_busy", int'(busy_mid_b), 4);

        for (int k = 1; k <= 14; k++) begin
            expc = 128 - 10 * k;
            if (expc < 0) expc = 0;
            wait_fs_b(10, n);
            frame_b(-1, 0, 0);
            chk($sformatf("b_ramp%0d_ch2_high_clk", k), hb[2], 2 * (100 + expc));
            chk($sformatf("b_ramp%0d_busy2", k), int'(busy_mid_b[2]), (expc != 0) ? 1 : 0);
        end
        chk("b_ramp_ch0_high_clk", hb[0], 456);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
